// File: rtl/round_timer_ctrl_pkg.sv
// rtl/round_timer_ctrl_pkg.sv - shared FSM encoding and default level timing constants
package round_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEF_T0         = 60;
  localparam int DEF_T1         = 45;
  localparam int DEF_T2         = 30;
  localparam int DEF_T3         = 20;
  localparam int DEF_STEP       = 5;
  localparam int DEF_MIN_TIME   = 10;
  localparam int DEF_MAX_ROUNDS = 5;
  localparam int DEF_WARN_TH    = 10;

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - rising-edge detector producing a one-cycle pulse
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign pulse = din & ~prev_q;

endmodule

// File: rtl/round_timer_ctrl.sv
// rtl/round_timer_ctrl.sv - round-based game controller driving a seconds countdown stage
module round_timer_ctrl
  import round_timer_ctrl_pkg::*;
#(
  parameter int T0         = DEF_T0,
  parameter int T1         = DEF_T1,
  parameter int T2         = DEF_T2,
  parameter int T3         = DEF_T3,
  parameter int STEP       = DEF_STEP,
  parameter int MIN_TIME   = DEF_MIN_TIME,
  parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
  parameter int WARN_TH    = DEF_WARN_TH
) (
  input  logic        CLK_count,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        hit,
  input  logic [1:0]  level_sel,
  input  logic [29:0] last_time,
  output logic [26:0] start_time,
  output logic        setting_change,
  output logic        clock_go,
  output logic [3:0]  round_num,
  output logic [15:0] score,
  output logic        warn,
  output logic        game_over,
  output logic        win
);

  state_t      state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [3:0]  round_q, round_d;
  logic [15:0] score_q, score_d;
  logic        win_q, win_d;
  logic [26:0] start_time_q, start_time_d;
  logic        start_p, pause_p, hit_p;
  logic [16:0] score_sum;

  edge_pulse u_start (.clk(CLK_count), .rst(rst), .din(btn_start), .pulse(start_p));
  edge_pulse u_pause (.clk(CLK_count), .rst(rst), .din(btn_pause), .pulse(pause_p));
  edge_pulse u_hit   (.clk(CLK_count), .rst(rst), .din(hit),       .pulse(hit_p));

  // Shrinking round time with a floor; the subtraction is guarded so it never wraps.
  function automatic logic [26:0] round_time(input logic [1:0] lvl, input logic [3:0] rnd);
    logic [26:0] base, dec, diff;
    case (lvl)
      2'd0:    base = 27'(T0);
      2'd1:    base = 27'(T1);
      2'd2:    base = 27'(T2);
      default: base = 27'(T3);
    endcase
    dec  = (27'(rnd) - 27'd1) * 27'(STEP);
    diff = (dec >= base) ? 27'd0 : base - dec;
    return (diff > 27'(MIN_TIME)) ? diff : 27'(MIN_TIME);
  endfunction

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    round_d      = round_q;
    score_d      = score_q;
    win_d        = win_q;
    start_time_d = start_time_q;
    score_sum    = {1'b0, score_q} + {1'b0, last_time[15:0]};
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_p) begin
          state_d      = S_ARM;
          level_d      = level_sel;
          round_d      = 4'd1;
          score_d      = 16'd0;
          win_d        = 1'b0;
          start_time_d = round_time(level_sel, 4'd1);
        end
      end
      S_ARM: state_d = S_RUN;
      S_RUN: begin
        if (hit_p) begin
          score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          if (round_q == 4'(MAX_ROUNDS)) begin
            state_d = S_DONE;
            win_d   = 1'b1;
          end else begin
            state_d      = S_ARM;
            round_d      = round_q + 4'd1;
            start_time_d = round_time(level_q, round_q + 4'd1);
          end
        end else if (last_time == 30'd0) begin
          state_d = S_DONE;
          win_d   = 1'b0;
        end else if (pause_p) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: if (pause_p) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_count or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      level_q      <= 2'd0;
      round_q      <= 4'd1;
      score_q      <= 16'd0;
      win_q        <= 1'b0;
      start_time_q <= 27'(T0);
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      round_q      <= round_d;
      score_q      <= score_d;
      win_q        <= win_d;
      start_time_q <= start_time_d;
    end
  end

  assign start_time     = start_time_q;
  assign round_num      = round_q;
  assign score          = score_q;
  assign setting_change = (state_q == S_IDLE) || (state_q == S_ARM);
  assign clock_go       = (state_q == S_RUN);
  assign game_over      = (state_q == S_DONE);
  assign win            = win_q && (state_q == S_DONE);
  assign warn           = ((state_q == S_RUN) || (state_q == S_PAUSE)) &&
                          (last_time != 30'd0) && (last_time <= 30'(WARN_TH));

endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb/tb_round_timer_ctrl.sv - directed and randomized checks of round_timer_ctrl against a game model
module tb_round_timer_ctrl;

  logic        CLK_count = 1'b0;
  logic        rst = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_pause = 1'b0;
  logic        hit = 1'b0;
  logic [1:0]  level_sel = 2'd0;
  logic [29:0] last_time = 30'd0;
  logic [26:0] start_time;
  logic        setting_change, clock_go, warn, game_over, win;
  logic [3:0]  round_num;
  logic [15:0] score;

  round_timer_ctrl dut (
    .CLK_count(CLK_count), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause),
    .hit(hit), .level_sel(level_sel), .last_time(last_time), .start_time(start_time),
    .setting_change(setting_change), .clock_go(clock_go), .round_num(round_num),
    .score(score), .warn(warn), .game_over(game_over), .win(win)
  );

  always #5 CLK_count = ~CLK_count;

  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
  int m_mode, m_level, m_round, m_score, m_st;
  bit m_win, m_ps, m_pp, m_ph;
  int n_assert = 0;
  int n_fail = 0;

  function automatic int game_round_time(input int lvl, input int r);
    int base[4];
    int t;
    base = '{60, 45, 30, 20};
    t = base[lvl] - (r - 1) * 5;
    return (t < 10) ? 10 : t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_level = 0; m_round = 1; m_score = 0; m_st = 60; m_win = 0;
    m_ps = 0; m_pp = 0; m_ph = 0;
  endtask

  task automatic new_game(input int lv);
    m_mode = M_ARM; m_level = lv; m_round = 1; m_score = 0; m_win = 0;
    m_st = game_round_time(lv, 1);
  endtask

  task automatic model_update(input bit s, input bit p, input bit h, input int lv, input logic [29:0] lt);
    bit sp, pp, hp;
    sp = s && !m_ps; pp = p && !m_pp; hp = h && !m_ph;
    m_ps = s; m_pp = p; m_ph = h;
    if (m_mode == M_IDLE || m_mode == M_DONE) begin
      if (sp) new_game(lv);
    end else if (m_mode == M_ARM) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (hp) begin
        m_score = m_score + int'(lt[15:0]);
        if (m_score > 65535) m_score = 65535;
        if (m_round == 5) begin
          m_mode = M_DONE; m_win = 1;
        end else begin
          m_round++; m_st = game_round_time(m_level, m_round); m_mode = M_ARM;
        end
      end else if (lt == 0) begin
        m_mode = M_DONE; m_win = 0;
      end else if (pp) begin
        m_mode = M_PAUSE;
      end
    end else if (m_mode == M_PAUSE) begin
      if (pp) m_mode = M_RUN;
    end
  endtask

  task automatic check_all();
    bit active;
    active = (m_mode == M_RUN || m_mode == M_PAUSE);
    check("start_time", 32'(start_time), 32'(m_st));
    check("setting_change", 32'(setting_change), 32'(m_mode == M_IDLE || m_mode == M_ARM));
    check("clock_go", 32'(clock_go), 32'(m_mode == M_RUN));
    check("round_num", 32'(round_num), 32'(m_round));
    check("score", 32'(score), 32'(m_score));
    check("game_over", 32'(game_over), 32'(m_mode == M_DONE));
    check("win", 32'(win), 32'(m_mode == M_DONE && m_win));
    check("warn", 32'(warn), 32'(active && last_time != 0 && last_time <= 10));
  endtask

  task automatic step(input bit s, input bit p, input bit h, input int lv, input logic [29:0] lt);
    @(negedge CLK_count);
    btn_start = s; btn_pause = p; hit = h; level_sel = 2'(lv); last_time = lt;
    @(posedge CLK_count);
    #1;
    model_update(s, p, h, lv, lt);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge CLK_count);
    #2;
    rst = 1'b1; btn_start = 0; btn_pause = 0; hit = 0;
    #1;
    model_reset();
    check_all();
    @(negedge CLK_count);
    rst = 1'b0;
  endtask

  initial begin
    bit s, p, h;
    int lv, r;
    logic [29:0] lt;

    do_reset();
    check("reset_start_time", 32'(start_time), 32'd60);

    // level 2 start, first hit with 12 seconds left
    step(1, 0, 0, 2, 100);
    check("arm_t2", 32'(start_time), 32'd30);
    step(0, 0, 0, 2, 100);
    check("run_go", 32'(clock_go), 32'd1);
    step(0, 0, 1, 2, 12);
    check("hit_score", 32'(score), 32'd12);
    check("arm_r2", 32'(start_time), 32'd25);
    step(0, 0, 0, 2, 12);

    // countdown to zero without a hit: warn window then loss
    for (int t = 11; t >= 0; t--) step(0, 0, 0, 0, 30'(t));
    check("timeout_over", 32'(game_over), 32'd1);
    check("timeout_win", 32'(win), 32'd0);

    // level 3 full game with a pause in round 2 and a winning hit at zero in round 5
    step(1, 0, 0, 3, 50);
    step(0, 0, 0, 3, 50);
    for (int rr = 1; rr <= 5; rr++) begin
      if (rr == 2) begin
        step(0, 1, 0, 3, 40);
        check("paused_go", 32'(clock_go), 32'd0);
        step(0, 0, 1, 3, 40);
        step(0, 0, 0, 3, 40);
        step(0, 1, 0, 3, 40);
        check("resumed_go", 32'(clock_go), 32'd1);
        step(0, 0, 0, 3, 40);
      end
      step(0, 0, 1, 3, (rr == 5) ? 30'd0 : 30'(rr * 7));
      if (rr == 2) check("arm_r3_floor", 32'(start_time), 32'd10);
      if (rr == 4) check("arm_r5_floor", 32'(start_time), 32'd10);
      step(0, 0, 0, 3, 50);
    end
    check("win_flag", 32'(win), 32'd1);

    // reset while paused in round 3
    step(1, 0, 0, 0, 100);
    step(0, 0, 0, 0, 100);
    step(0, 0, 1, 0, 100);
    step(0, 0, 0, 0, 100);
    step(0, 0, 1, 0, 100);
    step(0, 0, 0, 0, 100);
    step(0, 1, 0, 0, 100);
    do_reset();
    check("rst_round", 32'(round_num), 32'd1);
    check("rst_t0", 32'(start_time), 32'd60);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      s  = ($urandom_range(0, 7) == 0);
      p  = ($urandom_range(0, 7) == 0);
      h  = ($urandom_range(0, 5) == 0);
      lv = int'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 15));
      if (r == 0)      lt = 30'd0;
      else if (r == 1) lt = 30'($urandom);
      else             lt = 30'($urandom_range(1, 20));
      step(s, p, h, lv, lt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
